// File: rtl/bcd_rr_arbiter_pkg.sv
// Shared types and constants for the BCD round-robin arbiter.
//   N_MAX         : widest supported requester vector (10, one per decimal digit)
//   BCD_W         : width of a BCD digit index
//   HOLD_W        : width of the saturating grant-hold counter
//   state_t       : arbiter FSM states
//   dbg_t         : debug snapshot of the FSM exported by the top
//   bcd_to_onehot : decimal index -> one-hot grant vector
package bcd_arb_pkg;

  localparam int N_MAX  = 10;
  localparam int BCD_W  = 4;
  localparam int HOLD_W = 8;

  typedef logic [BCD_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    state_t            state;
    idx_t              last_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_at_limit; // hold_cnt == MAX_HOLD (forces release only with timeout)
  } dbg_t;

  function automatic logic [N_MAX-1:0] bcd_to_onehot(input idx_t idx);
    logic [N_MAX-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/bcd_rr_arbiter_if.sv
// Request/grant bundle between requesting units (master) and the arbiter (slave).
//   req     : per-requester request level
//   done    : current owner finished
//   gnt     : registered one-hot grant, zero when no owner
//   gnt_bcd : BCD index of the granted bit, 0 when no owner
//   gnt_vld : gnt != 0
//   preempt : one-cycle pulse when a grant is taken away by timeout
// Handshake: a requester raises req[i] and holds it until it sees gnt[i]; it
// owns the resource while gnt[i]=1 and ends ownership either by pulsing done
// or by dropping req[i]. done is only looked at while a grant is active.
interface bcd_rr_arbiter_if;
  import bcd_arb_pkg::*;

  logic [N_MAX-1:0] req;
  logic             done;
  logic [N_MAX-1:0] gnt;
  idx_t             gnt_bcd;
  logic             gnt_vld;
  logic             preempt;

  modport master (output req, done, input gnt, gnt_bcd, gnt_vld, preempt);
  modport slave  (input req, done, output gnt, gnt_bcd, gnt_vld, preempt);

endinterface

// File: rtl/bcd_rr_arbiter_rr_pick.sv
// Combinational rotated-priority picker.
//   req         : request vector (bits >= N_REQ ignored)
//   last_ptr    : index of the previous owner; scan starts one above it, wrapping
//   pick_onehot : one-hot winner, zero when nothing requests
//   pick_bcd    : BCD index of the winner, 0 when nothing requests
//   pick_any    : some requester in range is asserting req
module rr_pick
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 10
) (
  input  logic [N_MAX-1:0] req,
  input  idx_t             last_ptr,
  output logic [N_MAX-1:0] pick_onehot,
  output idx_t             pick_bcd,
  output logic             pick_any
);

  logic [N_MAX-1:0] req_m;

  always_comb begin
    req_m = '0;
    req_m[N_REQ-1:0] = req[N_REQ-1:0];
  end

  // Walk the rotation from farthest to nearest so the nearest set bit
  // above last_ptr is the final assignment and therefore wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_bcd = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_ptr) + k) % N_REQ;
      if (req_m[idx]) pick_bcd = idx_t'(idx);
    end
  end

  assign pick_any    = |req_m;
  assign pick_onehot = pick_any ? bcd_to_onehot(pick_bcd) : '0;

endmodule

// File: rtl/bcd_rr_arbiter.sv
// Round-robin arbiter sharing one decimal-digit resource among up to 10
// requesters. Grants are registered one-hot plus BCD index; an owner keeps the
// grant until done or until it drops its request, then one turnaround cycle
// (RELEASE) and one IDLE cycle pass before the next grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bcd_rr_arbiter_if.slave (req, done in; gnt, gnt_bcd, gnt_vld, preempt out)
//   dbg        : FSM state, priority pointer and hold counter
// Optional feature: define ARB_TIMEOUT_EN to force release after MAX_HOLD
// cycles of ownership, flagged by a one-cycle preempt pulse.
module bcd_rr_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ    = 10,
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_rr_arbiter_if.slave      bus,
  output dbg_t                 dbg
);

  state_t            state;
  idx_t              last_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_MAX-1:0]  gnt_r;
  idx_t              gnt_bcd_r;
  logic              gnt_vld_r;
  logic              preempt_r;

  logic [N_MAX-1:0]  pick_onehot;
  idx_t              pick_bcd;
  logic              pick_any;

  logic              owner_req;
  logic              hold_at_limit;
  logic              timeout;
  logic              release_now;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req         (bus.req),
    .last_ptr    (last_ptr),
    .pick_onehot (pick_onehot),
    .pick_bcd    (pick_bcd),
    .pick_any    (pick_any)
  );

  assign owner_req     = bus.req[gnt_bcd_r];
  assign hold_at_limit = (hold_cnt == HOLD_W'(MAX_HOLD));

`ifdef ARB_TIMEOUT_EN
  assign timeout = hold_at_limit;
`else
  assign timeout = 1'b0;
`endif

  assign release_now = bus.done || !owner_req || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_ptr  <= idx_t'(N_REQ-1);
      hold_cnt  <= '0;
      gnt_r     <= '0;
      gnt_bcd_r <= '0;
      gnt_vld_r <= 1'b0;
      preempt_r <= 1'b0;
    end else begin
      preempt_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_r     <= pick_onehot;
            gnt_bcd_r <= pick_bcd;
            gnt_vld_r <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt_r     <= '0;
            gnt_bcd_r <= '0;
            gnt_vld_r <= 1'b0;
            last_ptr  <= gnt_bcd_r;
            state     <= RELEASE;
            // A timeout coinciding with done or a request drop is an
            // ordinary release, not a preemption.
            preempt_r <= timeout && !bus.done && owner_req;
          end else if (hold_cnt != {HOLD_W{1'b1}}) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.gnt_bcd = gnt_bcd_r;
  assign bus.gnt_vld = gnt_vld_r;
  assign bus.preempt = preempt_r;

  assign dbg.state         = state;
  assign dbg.last_ptr      = last_ptr;
  assign dbg.hold_cnt      = hold_cnt;
  assign dbg.hold_at_limit = hold_at_limit;

endmodule

// File: tb/tb_bcd_rr_arbiter.sv
module tb_bcd_rr_arbiter;
  import bcd_arb_pkg::*;

  localparam int N   = 10;
  localparam int MXH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_rr_arbiter_if bus();
  dbg_t dbg;

  bcd_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dbg   (dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [9:0] req;
    logic       done;
    logic [9:0] gnt;
    logic [3:0] bcd;
    logic       vld;
  } vec_t;
  vec_t tbl[15];

  // ---------------- reference model ----------------
  int m_owner;  // -1 when nobody owns the resource
  int m_last;
  int m_gap;    // remaining forced-idle edges before arbitration resumes
  int m_held;
  bit m_pre;

  function automatic int m_pick(input logic [9:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gap = 0; m_held = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [9:0] r, input logic d);
    bit to;
    m_pre = 0;
    if (m_owner >= 0) begin
`ifdef ARB_TIMEOUT_EN
      to = (m_held == MXH);
`else
      to = 0;
`endif
      if (d || !r[m_owner] || to) begin
        m_pre = to && !d && r[m_owner];
        m_last = m_owner;
        m_owner = -1;
        m_gap = 2;
      end else if (m_held < 255) begin
        m_held++;
      end
    end else if (m_gap > 1) begin
      m_gap--;        // turnaround edge
    end else begin
      m_gap = 0;
      m_owner = m_pick(r, m_last);
      if (m_owner >= 0) m_held = 1;
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [9:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = r;
    bus.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    int budget;
    logic [3:0] e;
    bus.req = '0;
    bus.done = 1'b0;

    // Table for single request, owner drop, pending re-arbitration, done in IDLE, wrap.
    tbl[0]  = '{10'h020, 1'b0, 10'h020, 4'd5, 1'b1};
    tbl[1]  = '{10'h020, 1'b1, 10'h000, 4'd0, 1'b0};
    tbl[2]  = '{10'h000, 1'b0, 10'h000, 4'd0, 1'b0};
    tbl[3]  = '{10'h008, 1'b0, 10'h008, 4'd3, 1'b1};
    tbl[4]  = '{10'h014, 1'b0, 10'h000, 4'd0, 1'b0};
    tbl[5]  = '{10'h014, 1'b0, 10'h000, 4'd0, 1'b0};
    tbl[6]  = '{10'h014, 1'b0, 10'h010, 4'd4, 1'b1};
    tbl[7]  = '{10'h014, 1'b1, 10'h000, 4'd0, 1'b0};
    tbl[8]  = '{10'h004, 1'b0, 10'h000, 4'd0, 1'b0};
    tbl[9]  = '{10'h004, 1'b0, 10'h004, 4'd2, 1'b1};
    tbl[10] = '{10'h004, 1'b0, 10'h004, 4'd2, 1'b1};
    tbl[11] = '{10'h000, 1'b0, 10'h000, 4'd0, 1'b0};
    tbl[12] = '{10'h000, 1'b0, 10'h000, 4'd0, 1'b0};
    tbl[13] = '{10'h000, 1'b1, 10'h000, 4'd0, 1'b0};
    tbl[14] = '{10'h200, 1'b0, 10'h200, 4'd9, 1'b1};

    // 1: reset with all requests pending
    @(negedge clk);
    bus.req = 10'h3FF;
    #1;
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_bcd", 32'(bus.gnt_bcd), 32'h0);
    check("reset_vld", 32'(bus.gnt_vld), 32'h0);
    check("reset_pre", 32'(bus.preempt), 32'h0);
    check("reset_state", 32'(dbg.state), 32'(IDLE));
    check("reset_last", 32'(dbg.last_ptr), 32'd9);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("first_gnt", 32'(bus.gnt), 32'h001);
    check("first_bcd", 32'(bus.gnt_bcd), 32'd0);

    // 3: all requests, done always high -> 1..9 then wrap to 0
    bus.done = 1'b1;
    for (int i = 1; i <= 10; i++) exp_q.push_back(4'(i % 10));
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      tick();
      budget++;
      if (bus.gnt_vld) begin
        e = exp_q.pop_front();
        check("wrap_bcd", 32'(bus.gnt_bcd), 32'(e));
        check("wrap_onehot", 32'(bus.gnt), 32'(1 << e));
      end
    end
    check("wrap_budget", 32'(exp_q.size()), 32'd0);

    // 2 + 4: table-driven vectors from a fresh reset
    do_reset(10'h000);
    foreach (tbl[i]) begin
      bus.req = tbl[i].req;
      bus.done = tbl[i].done;
      tick();
      check($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_bcd", i), 32'(bus.gnt_bcd), 32'(tbl[i].bcd));
      check($sformatf("tbl%0d_vld", i), 32'(bus.gnt_vld), 32'(tbl[i].vld));
    end

    // 5: hold limit
    do_reset(10'h080);
    tick();
    check("hold_first_bcd", 32'(bus.gnt_bcd), 32'd7);
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    while (bus.gnt_vld && cnt < 20) begin
      cnt++;
      tick();
    end
    check("timeout_len", 32'(cnt), 32'(MXH));
    check("timeout_preempt", 32'(bus.preempt), 32'd1);
    tick();
    check("preempt_pulse_end", 32'(bus.preempt), 32'd0);
    budget = 0;
    while (!bus.gnt_vld && budget < 10) begin
      tick();
      budget++;
    end
    check("regrant_bcd", 32'(bus.gnt_bcd), 32'd7);
    for (int i = 1; i < MXH; i++) tick();
    bus.done = 1'b1;
    tick();
    check("done_timeout_vld", 32'(bus.gnt_vld), 32'd0);
    check("done_timeout_pre", 32'(bus.preempt), 32'd0);
    bus.done = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nolimit_pre", 32'(bus.preempt), 32'd0);
    end
    check("nolimit_gnt", 32'(bus.gnt), 32'h080);
`endif

    // 6: asynchronous reset while owner 6 holds the grant
    do_reset(10'h040);
    tick();
    check("mid_gnt_before", 32'(bus.gnt), 32'h040);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check("mid_rst_bcd", 32'(bus.gnt_bcd), 32'h0);
    check("mid_rst_vld", 32'(bus.gnt_vld), 32'h0);
    bus.req = 10'h041;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_rst_gnt", 32'(bus.gnt), 32'h001);

    // Random traffic against the reference model
    do_reset(10'h000);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) bus.req = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) == 0) bus.req = '0;
      bus.done = ($urandom_range(0, 5) == 0);
      tick();
      model_step(bus.req, bus.done);
      check("rnd_gnt", 32'(bus.gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'h0);
      check("rnd_bcd", 32'(bus.gnt_bcd), (m_owner >= 0) ? 32'(m_owner) : 32'h0);
      check("rnd_vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
      check("rnd_pre", 32'(bus.preempt), 32'(m_pre));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
